// File: rtl/wash_pkg.sv
// Shared state encodings, duration defaults and actuator decode for the wash controller.
package wash_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned STATE_W = 4;

  localparam int unsigned DEF_WASH_CYC  = 1000;
  localparam int unsigned DEF_RINSE_CYC = 600;
  localparam int unsigned DEF_SPIN_CYC  = 800;
  localparam int unsigned DEF_FILL_TMO  = 400;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_FILL   = 4'd1,
    ST_WASH   = 4'd2,
    ST_DRAIN1 = 4'd3,
    ST_RFILL  = 4'd4,
    ST_RINSE  = 4'd5,
    ST_DRAIN2 = 4'd6,
    ST_SPIN   = 4'd7,
    ST_FAULT  = 4'd8
  } wash_state_e;

  typedef struct packed {
    logic water_valve;
    logic drain_pump;
    logic motor_on;
    logic motor_fast;
    logic door_lock;
  } act_t;

  // A zero duration still occupies the state for one cycle.
  function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  function automatic act_t decode_act(input wash_state_e s);
    act_t a;
    a = '0;
    case (s)
      ST_FILL, ST_RFILL: begin
        a.water_valve = 1'b1;
        a.door_lock   = 1'b1;
      end
      ST_WASH, ST_RINSE: begin
        a.motor_on  = 1'b1;
        a.door_lock = 1'b1;
      end
      ST_DRAIN1, ST_DRAIN2: begin
        a.drain_pump = 1'b1;
        a.door_lock  = 1'b1;
      end
      ST_SPIN: begin
        a.drain_pump = 1'b1;
        a.motor_on   = 1'b1;
        a.motor_fast = 1'b1;
        a.door_lock  = 1'b1;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wash_cycle_controller_phase_timer.sv
// Saturating 32-bit phase countdown; expire_c flags the last cycle of a loaded phase.
module phase_timer
  import wash_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload wins; otherwise count down and hold at zero so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/wash_cycle_controller.sv
// Wash/rinse/spin sequencer with fill/drain timeouts, abort path and sticky fault.
module wash_cycle_controller
  import wash_pkg::*;
#(
  parameter int unsigned WASH_CYC  = DEF_WASH_CYC,
  parameter int unsigned RINSE_CYC = DEF_RINSE_CYC,
  parameter int unsigned SPIN_CYC  = DEF_SPIN_CYC,
  parameter int unsigned FILL_TMO  = DEF_FILL_TMO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cancel,
  input  logic               door_closed,
  input  logic               level_full,
  input  logic               level_empty,
  output logic               water_valve,
  output logic               drain_pump,
  output logic               motor_on,
  output logic               motor_fast,
  output logic               door_lock,
  output logic               done,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  wash_state_e      state_q, state_d;
  logic             abort_q, abort_d;
  act_t             act_q, act_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_exp_c;

  phase_timer u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .value    (tmr_value),
    .expire_c (tmr_exp_c)
  );

  // Next state: door open beats cancel beats timeout beats normal progress.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start && door_closed) state_d = ST_FILL;
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        if (!door_closed) begin
          state_d = ST_FAULT;
        end else if (cancel) begin
          state_d = ST_DRAIN2;
          abort_d = 1'b1;
        end else begin
          case (state_q)
            ST_FILL: begin
              if (tmr_exp_c)       state_d = ST_FAULT;
              else if (level_full) state_d = ST_WASH;
            end
            ST_WASH: begin
              if (tmr_exp_c) state_d = ST_DRAIN1;
            end
            ST_DRAIN1: begin
              if (tmr_exp_c)        state_d = ST_FAULT;
              else if (level_empty) state_d = ST_RFILL;
            end
            ST_RFILL: begin
              if (tmr_exp_c)       state_d = ST_FAULT;
              else if (level_full) state_d = ST_RINSE;
            end
            ST_RINSE: begin
              if (tmr_exp_c) state_d = ST_DRAIN2;
            end
            ST_DRAIN2: begin
              if (tmr_exp_c)        state_d = ST_FAULT;
              else if (level_empty) state_d = abort_q ? ST_IDLE : ST_SPIN;
            end
            ST_SPIN: begin
              if (tmr_exp_c) state_d = ST_IDLE;
            end
            default: state_d = ST_FAULT;
          endcase
        end
      end
    endcase
  end

  // Phase length for the state being entered; reload only on an actual change.
  always_comb begin
    tmr_load  = (state_d != state_q);
    tmr_value = '0;
    case (state_d)
      ST_FILL, ST_RFILL, ST_DRAIN1, ST_DRAIN2: tmr_value = clamp_dur(CNT_W'(FILL_TMO));
      ST_WASH:  tmr_value = clamp_dur(CNT_W'(WASH_CYC));
      ST_RINSE: tmr_value = clamp_dur(CNT_W'(RINSE_CYC));
      ST_SPIN:  tmr_value = clamp_dur(CNT_W'(SPIN_CYC));
      default:  tmr_value = '0;
    endcase
  end

  always_comb begin
    act_d   = decode_act(state_d);
    done_d  = (state_q == ST_SPIN) && (state_d == ST_IDLE);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      act_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      act_q   <= act_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign water_valve = act_q.water_valve;
  assign drain_pump  = act_q.drain_pump;
  assign motor_on    = act_q.motor_on;
  assign motor_fast  = act_q.motor_fast;
  assign door_lock   = act_q.door_lock;
  assign done        = done_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller: normal cycle, timeout, cancel, door fault, reset, zero duration.
module tb_wash_cycle_controller;

  logic clk = 1'b0;
  logic reset, start, cancel, door_closed, level_full, level_empty;
  logic water_valve, drain_pump, motor_on, motor_fast, door_lock, done, fault;
  logic [3:0] state;
  logic z_water_valve, z_drain_pump, z_motor_on, z_motor_fast, z_door_lock, z_done, z_fault;
  logic [3:0] z_state;

  int n_cmp = 0;
  int n_err = 0;
  int both_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  wash_cycle_controller #(
    .WASH_CYC(5), .RINSE_CYC(3), .SPIN_CYC(4), .FILL_TMO(10)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel),
    .door_closed(door_closed), .level_full(level_full), .level_empty(level_empty),
    .water_valve(water_valve), .drain_pump(drain_pump), .motor_on(motor_on),
    .motor_fast(motor_fast), .door_lock(door_lock), .done(done), .fault(fault),
    .state(state)
  );

  wash_cycle_controller #(
    .WASH_CYC(0), .RINSE_CYC(3), .SPIN_CYC(4), .FILL_TMO(10)
  ) u_dut_zero (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel),
    .door_closed(door_closed), .level_full(level_full), .level_empty(level_empty),
    .water_valve(z_water_valve), .drain_pump(z_drain_pump), .motor_on(z_motor_on),
    .motor_fast(z_motor_fast), .door_lock(z_door_lock), .done(z_done), .fault(z_fault),
    .state(z_state)
  );

  always @(negedge clk) begin
    if (done && fault) both_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Actuators packed as {water_valve, drain_pump, motor_on, motor_fast, door_lock}.
  task automatic check_act(input string tag, input logic [4:0] exp);
    check(tag, 32'({water_valve, drain_pump, motor_on, motor_fast, door_lock}), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // From IDLE with door closed and drum empty; stop_at returns on first cycle of that state.
  task automatic run_normal(input string tag, input int stop_at, input bit chk_zero);
    int n;
    int d0;
    start = 1'b1;
    tick();
    start = 1'b0;
    level_empty = 1'b0;
    check({tag, "_fill"}, 32'(state), 1);
    check_act({tag, "_fill_act"}, 5'b10001);
    tick();
    check({tag, "_fill2"}, 32'(state), 1);
    level_full = 1'b1;
    tick();
    level_full = 1'b0;
    check({tag, "_wash"}, 32'(state), 2);
    check_act({tag, "_wash_act"}, 5'b00101);
    if (chk_zero) check({tag, "_z_wash"}, 32'(z_state), 2);
    if (stop_at == 2) return;
    n = 0;
    while (state == 4'd2 && n < 50) begin
      n++;
      tick();
      if (chk_zero && n == 1) check({tag, "_z_wash_len1"}, 32'(z_state), 3);
    end
    check({tag, "_wash_len"}, 32'(n), 5);
    check({tag, "_drain1"}, 32'(state), 3);
    check_act({tag, "_drain1_act"}, 5'b01001);
    tick();
    level_empty = 1'b1;
    tick();
    level_empty = 1'b0;
    check({tag, "_rfill"}, 32'(state), 4);
    check_act({tag, "_rfill_act"}, 5'b10001);
    tick();
    level_full = 1'b1;
    tick();
    level_full = 1'b0;
    check({tag, "_rinse"}, 32'(state), 5);
    check_act({tag, "_rinse_act"}, 5'b00101);
    if (stop_at == 5) return;
    n = 0;
    while (state == 4'd5 && n < 50) begin
      n++;
      tick();
    end
    check({tag, "_rinse_len"}, 32'(n), 3);
    check({tag, "_drain2"}, 32'(state), 6);
    tick();
    level_empty = 1'b1;
    tick();
    check({tag, "_spin"}, 32'(state), 7);
    check_act({tag, "_spin_act"}, 5'b01111);
    if (stop_at == 7) return;
    d0 = done_cnt;
    n = 0;
    while (state == 4'd7 && n < 50) begin
      check({tag, "_spin_nodone"}, 32'(done), 0);
      n++;
      tick();
    end
    check({tag, "_spin_len"}, 32'(n), 4);
    check({tag, "_idle"}, 32'(state), 0);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_nofault"}, 32'(fault), 0);
    check_act({tag, "_idle_act"}, 5'b00000);
    tick();
    check({tag, "_done_off"}, 32'(done), 0);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int n;
    int d0;
    reset = 1'b0; start = 1'b0; cancel = 1'b0;
    door_closed = 1'b1; level_full = 1'b0; level_empty = 1'b1;

    // Reset state
    do_reset();
    check("rst_state", 32'(state), 0);
    check_act("rst_act", 5'b00000);
    check("rst_done", 32'(done), 0);
    check("rst_fault", 32'(fault), 0);

    // Normal cycle, plus zero-length WASH on the second instance
    run_normal("norm", 99, 1'b1);

    // Fill timeout, sticky fault
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state == 4'd1 && n < 50) begin
      n++;
      tick();
    end
    check("tmo_len", 32'(n), 10);
    check("tmo_state", 32'(state), 8);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_done", 32'(done), 0);
    check_act("tmo_act", 5'b00000);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("tmo_sticky_state", 32'(state), 8);
    check("tmo_sticky_fault", 32'(fault), 1);
    do_reset();
    check("tmo_rst_state", 32'(state), 0);
    check("tmo_rst_fault", 32'(fault), 0);

    // Cancel in WASH cycle 2
    level_empty = 1'b1;
    run_normal("cnl", 2, 1'b0);
    d0 = done_cnt;
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cnl_drain2", 32'(state), 6);
    check_act("cnl_drain2_act", 5'b01001);
    level_empty = 1'b1;
    tick();
    check("cnl_idle", 32'(state), 0);
    check("cnl_done", 32'(done), 0);
    tick();
    check("cnl_no_pulse", 32'(done_cnt - d0), 0);

    // Door open and cancel together in SPIN
    run_normal("door", 7, 1'b0);
    door_closed = 1'b0;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("door_state", 32'(state), 8);
    check("door_fault", 32'(fault), 1);
    check_act("door_act", 5'b00000);
    door_closed = 1'b1;
    tick();
    check("door_sticky", 32'(state), 8);
    do_reset();

    // Reset mid-RINSE, then a full cycle
    level_empty = 1'b1;
    run_normal("rrst", 5, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rrst_state", 32'(state), 0);
    check_act("rrst_act", 5'b00000);
    check("rrst_done", 32'(done), 0);
    check("rrst_fault", 32'(fault), 0);
    level_empty = 1'b1;
    run_normal("rerun", 99, 1'b0);

    // Start with door open is ignored
    door_closed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("open_state", 32'(state), 0);
    check("open_lock", 32'(door_lock), 0);
    tick();
    check("open_state2", 32'(state), 0);
    door_closed = 1'b1;

    check("done_fault_overlap", 32'(both_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wash_cycle_controller.md
WASH_CYCLE_CONTROLLER -- requirements
Module: wash_cycle_controller

Interface
REQ-001 Parameters SHALL be: WASH_CYC (32, default 1000), wash agitation cycles; RINSE_CYC (32, default 600), rinse agitation cycles; SPIN_CYC (32, default 800), spin cycles; FILL_TMO (32, default 400), max fill/drain cycles before fault.
REQ-002 Ports SHALL be: clk in 1, sole clock, rising edge; reset in 1, synchronous, active-high.
REQ-003 start in 1, one-cycle request to begin a cycle, honoured only in IDLE.
REQ-004 cancel in 1, abort request, honoured in any running state.
REQ-005 door_closed in 1, door sensor, 1 = closed.
REQ-006 level_full in 1 and level_empty in 1, drum water-level sensors.
REQ-007 water_valve, drain_pump, motor_on, motor_fast, door_lock out 1 each, actuator enables.
REQ-008 done out 1, one-cycle pulse on normal completion; fault out 1, sticky error flag.
REQ-009 state out 4, current state encoding, for debug.

Function
REQ-010 States SHALL be IDLE, FILL, WASH, DRAIN1, RFILL, RINSE, DRAIN2, SPIN, FAULT, with fixed encodings 0-8 in that order.
REQ-011 IDLE: all actuators off; start=1 with door_closed=1 -> FILL next cycle; start with door_closed=0 is ignored.
REQ-012 FILL/RFILL: water_valve=1; exit to WASH/RINSE on first cycle level_full=1; FILL_TMO cycles without level_full -> FAULT.
REQ-013 WASH/RINSE: motor_on=1, motor_fast=0; the state SHALL last exactly WASH_CYC/RINSE_CYC cycles, then -> DRAIN1/DRAIN2.
REQ-014 DRAIN1/DRAIN2: drain_pump=1; exit on level_empty=1 to RFILL/SPIN; FILL_TMO cycles without level_empty -> FAULT.
REQ-015 SPIN: drain_pump=1, motor_on=1, motor_fast=1; lasts exactly SPIN_CYC cycles, then -> IDLE with done=1 during the first IDLE cycle.
REQ-016 A duration parameter of 0 SHALL behave as 1 (state occupies one cycle).
REQ-017 door_lock SHALL be 1 in every state except IDLE and FAULT.
REQ-018 door_closed=0 in any running state -> FAULT next cycle, all actuators off.
REQ-019 cancel in FILL, WASH, RFILL or RINSE -> DRAIN2; then SPIN is skipped: DRAIN2 exit on level_empty -> IDLE without done; cancel in DRAIN1/DRAIN2/SPIN -> DRAIN2 with the same abort exit.
REQ-020 Priority when simultaneous: door_closed=0 over cancel over timeout over normal transition.
REQ-021 FAULT: all actuators off, fault=1; left only by reset; start ignored.
REQ-022 The phase counter SHALL be 32-bit, reloaded on every state entry, and SHALL never wrap.
REQ-023 done and fault SHALL never assert in the same cycle.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, all actuators 0, done=0, fault=0, counter=0, and abort an in-progress cycle; reset dominates all inputs.

Structure
REQ-025 State encodings and default duration constants SHALL live in a shared package wash_pkg.
REQ-026 Countdown logic SHALL be a sub-module phase_timer (load, value, expire pulse, synchronous reset), instantiated once.
REQ-027 Outputs SHALL be registered, decoded from next state, with no combinational input-to-output path.

Verification
REQ-028 Normal cycle, WASH_CYC=5, RINSE_CYC=3, SPIN_CYC=4, sensors respond after 2 cycles -> states visit 1..7 in order, WASH 5 cycles, SPIN 4 cycles, done single pulse, fault=0.
REQ-029 FILL_TMO=10, level_full held 0 -> FAULT exactly 10 cycles after FILL entry; fault sticky until reset.
REQ-030 cancel during WASH cycle 2 -> DRAIN2 next cycle, IDLE after level_empty, done stays 0.
REQ-031 door_closed drops and cancel both asserted in SPIN -> FAULT, not DRAIN2.
REQ-032 reset pulsed mid-RINSE -> IDLE, all outputs 0 next cycle; subsequent start runs a full cycle.
REQ-033 start with door_closed=0 in IDLE -> remains IDLE, door_lock=0; WASH_CYC=0 -> WASH lasts 1 cycle.
